// File: rtl/lane_multiplexer.sv
// Selects one WIDTH-bit word out of a packed bus. The output is either combinational or taken
// from one flop. Selects that name a word past the last input give zero.
module lane_multiplexer #(
  parameter int WIDTH           = 32,
  parameter int NUM_INPUTS      = 2,
  parameter int ASCENDING_INDEX = 0,
  parameter int REGISTER_OUTPUT = 0,
  parameter int SEL_WIDTH       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH*NUM_INPUTS-1:0] in,
  input  logic [SEL_WIDTH-1:0]        select,
  output logic [WIDTH-1:0]            out
);

  // The word table is padded with zeros up to the full select range. Out-of-range selects then
  // land on a zero entry, and the mux stays a plain index with no range compare.
  localparam int DEPTH = (NUM_INPUTS == 1) ? 1 : (1 << SEL_WIDTH);

  logic [WIDTH-1:0] words [DEPTH];
  logic [WIDTH-1:0] sel_val;

  genvar i;
  for (i = 0; i < DEPTH; i++) begin : g_word
    if (i >= NUM_INPUTS) begin : g_pad
      assign words[i] = '0;
    end else if (ASCENDING_INDEX != 0) begin : g_asc
      assign words[i] = in[(NUM_INPUTS-1-i)*WIDTH +: WIDTH];
    end else begin : g_dsc
      assign words[i] = in[i*WIDTH +: WIDTH];
    end
  end

  if (NUM_INPUTS == 1) begin : g_single
    logic unused_select;
    assign unused_select = &{1'b0, select};
    assign sel_val       = words[0];
  end else begin : g_index
    assign sel_val = words[select];
  end

  if (REGISTER_OUTPUT != 0) begin : g_reg
    logic [WIDTH-1:0] out_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q <= '0;
      end else begin
        out_q <= sel_val;
      end
    end
    assign out = out_q;
  end else begin : g_comb
    logic unused_clk_reset;
    assign unused_clk_reset = &{1'b0, clk, reset};
    assign out              = sel_val;
  end

endmodule

// File: tb/tb_lane_multiplexer.sv
// Directed vectors for several mux configurations. Each vector pushes its expected value into a
// queue, and a separate monitor pops the queue and compares on every observe strobe.
module tb_lane_multiplexer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [511:0] in_a, in_d;
  logic [3:0]   sel_a, sel_d;
  logic [31:0]  out_a, out_d;
  logic [39:0]  in_f;
  logic [2:0]   sel_f;
  logic [7:0]   out_f;
  logic [127:0] in_r;
  logic [1:0]   sel_r;
  logic [31:0]  out_r;
  logic [15:0]  in_o;
  logic [0:0]   sel_o;
  logic [15:0]  out_o;

  lane_multiplexer #(.WIDTH(32), .NUM_INPUTS(16), .ASCENDING_INDEX(1), .REGISTER_OUTPUT(0)) u_a (
    .clk(clk), .reset(reset), .in(in_a), .select(sel_a), .out(out_a));
  lane_multiplexer #(.WIDTH(32), .NUM_INPUTS(16), .ASCENDING_INDEX(0), .REGISTER_OUTPUT(0)) u_d (
    .clk(clk), .reset(reset), .in(in_d), .select(sel_d), .out(out_d));
  lane_multiplexer #(.WIDTH(8), .NUM_INPUTS(5), .ASCENDING_INDEX(0), .REGISTER_OUTPUT(0)) u_f (
    .clk(clk), .reset(reset), .in(in_f), .select(sel_f), .out(out_f));
  lane_multiplexer #(.WIDTH(32), .NUM_INPUTS(4), .ASCENDING_INDEX(0), .REGISTER_OUTPUT(1)) u_r (
    .clk(clk), .reset(reset), .in(in_r), .select(sel_r), .out(out_r));
  lane_multiplexer #(.WIDTH(16), .NUM_INPUTS(1), .ASCENDING_INDEX(0), .REGISTER_OUTPUT(0)) u_o (
    .clk(clk), .reset(reset), .in(in_o), .select(sel_o), .out(out_o));

  typedef struct {
    int          dut;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  logic obs = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic expect_out(input int dut, input logic [31:0] exp, input string name);
    exp_t e;
    e.dut  = dut;
    e.exp  = exp;
    e.name = name;
    exp_q.push_back(e);
    #1 obs = 1'b1;
    #1 obs = 1'b0;
  endtask

  // Monitor: on each observe strobe, pop one expectation and compare it with the named output.
  always @(posedge obs) begin
    exp_t        e;
    logic [31:0] act;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL monitor_underflow: strobe seen with no expected value queued");
    end else begin
      e = exp_q.pop_front();
      case (e.dut)
        0:       act = out_a;
        1:       act = out_d;
        2:       act = {24'h0, out_f};
        3:       act = out_r;
        default: act = {16'h0, out_o};
      endcase
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_a = '0;
    in_a[511:480] = 32'hA000_0000;
    in_a[31:0]    = 32'h0000_000F;
    in_d  = in_a;
    sel_a = 4'd0;
    sel_d = 4'd0;
    in_f  = 40'h05_04_03_02_01;
    sel_f = 3'd4;
    in_r  = {32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_0000};
    sel_r = 2'd2;
    in_o  = 16'h1234;
    sel_o = 1'b0;

    // While reset is held, the registered output is 0 and the combinational paths still follow their inputs.
    expect_out(3, 32'h0, "reg_reset_async");
    expect_out(2, 32'h05, "comb_during_reset_sel4");
    expect_out(0, 32'hA000_0000, "comb_during_reset_asc");

    @(negedge clk);
    reset = 1'b0;
    expect_out(3, 32'h0, "reg_before_first_edge");
    @(posedge clk);
    expect_out(3, 32'hDEAD_BEEF, "reg_first_edge_load");

    @(negedge clk);
    sel_r = 2'd1;
    expect_out(3, 32'hDEAD_BEEF, "reg_hold_between_edges");
    @(posedge clk);
    expect_out(3, 32'h1234_5678, "reg_one_cycle_latency");

    @(negedge clk);
    reset = 1'b1;
    expect_out(3, 32'h0, "reg_midstream_reset");
    reset = 1'b0;
    expect_out(3, 32'h0, "reg_no_stale_after_reset");
    @(posedge clk);
    expect_out(3, 32'h1234_5678, "reg_reload_after_reset");

    // Same bus read in both word orders.
    @(negedge clk);
    sel_a = 4'd0;
    sel_d = 4'd0;
    expect_out(0, 32'hA000_0000, "asc_sel0");
    expect_out(1, 32'h0000_000F, "dsc_sel0");
    sel_a = 4'd15;
    sel_d = 4'd15;
    expect_out(0, 32'h0000_000F, "asc_sel15");
    expect_out(1, 32'hA000_0000, "dsc_sel15");
    sel_a = 4'd5;
    expect_out(0, 32'h0, "asc_sel5_zero_word");

    // Walking pattern: word i = 0x11111111 * i, swept one select per cycle.
    for (int i = 0; i < 16; i++) in_d[i*32 +: 32] = 32'h1111_1111 * i;
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      sel_d = s[3:0];
      expect_out(1, 32'h1111_1111 * s, $sformatf("walk_sel%0d", s));
    end

    // Five 8-bit inputs: selects 5..7 are past the last word and read as zero.
    sel_f = 3'd0;
    expect_out(2, 32'h01, "five_sel0");
    sel_f = 3'd4;
    expect_out(2, 32'h05, "five_sel4");
    sel_f = 3'd5;
    expect_out(2, 32'h00, "five_sel5");
    sel_f = 3'd6;
    expect_out(2, 32'h00, "five_sel6");
    sel_f = 3'd7;
    expect_out(2, 32'h00, "five_sel7");
    in_f = 40'hFF_80_7F_00_A5;
    sel_f = 3'd3;
    expect_out(2, 32'h80, "five_sel3_unmodified");

    // A single input ignores select.
    sel_o = 1'b0;
    expect_out(4, 32'h1234, "single_sel0");
    sel_o = 1'b1;
    expect_out(4, 32'h1234, "single_sel1");

    for (int w = 0; w < 100 && exp_q.size() != 0; w++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
